// File: rtl/apb_master.sv
// ----------------------------------------------------------------------------
// apb_master
//   Bridges a simple valid/ready command port onto an APB completer bus and
//   returns a one-cycle completion pulse carrying read data and error status.
//   Each transfer walks IDLE -> SETUP -> ACCESS. A completer that holds pready
//   low for TIMEOUT_CYCLES access cycles is abandoned, and the completion is
//   flagged as an error and a timeout.
//
// Parameters
//   TIMEOUT_CYCLES : access cycles with pready low before abort (1..255)
//
// Ports
//   pclk, presetn             : clock, synchronous active-low reset
//   cmd_valid / cmd_ready     : command handshake (ready only while IDLE)
//   cmd_write, cmd_addr,
//   cmd_wdata                 : command direction, address, write data
//   rsp_valid                 : one-cycle completion pulse
//   rsp_rdata, rsp_slverr,
//   rsp_timeout               : completion payload, held between pulses
//   paddr, pwdata, psel,
//   penable, pwrite           : registered APB request signals
//   pready, pslverr, prdata   : APB completer response
// ----------------------------------------------------------------------------
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_timeout,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Wait counter is 8 bits wide, enough for the full 1..255 timeout range.
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

    state_t      state_r;
    logic [7:0]  wait_cnt_r;
    logic [31:0] paddr_r;
    logic [31:0] pwdata_r;
    logic        psel_r;
    logic        penable_r;
    logic        pwrite_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_slverr_r;
    logic        rsp_timeout_r;

    // Transfer sequencer: state, APB request registers and completion payload.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= 8'd0;
            paddr_r       <= 32'h0000_0000;
            pwdata_r      <= 32'h0000_0000;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            // Completion is a single-cycle pulse; the payload registers hold.
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        paddr_r   <= cmd_addr;
                        pwdata_r  <= cmd_wdata;
                        pwrite_r  <= cmd_write;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        state_r   <= ST_SETUP;
                    end else begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    penable_r  <= 1'b1;
                    wait_cnt_r <= 8'd0;
                    state_r    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready is checked first so a completer answering on the
                    // last allowed cycle still completes normally.
                    if (pready) begin
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_slverr_r  <= pslverr;
                        rsp_timeout_r <= 1'b0;
                        rsp_rdata_r   <= (!pwrite_r && !pslverr) ? prdata : 32'h0000_0000;
                        state_r       <= ST_IDLE;
                    end else if (wait_cnt_r == (TIMEOUT_C - 8'd1)) begin
                        wait_cnt_r    <= TIMEOUT_C;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_slverr_r  <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        rsp_rdata_r   <= 32'h0000_0000;
                        state_r       <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_r == ST_IDLE);
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_slverr  = rsp_slverr_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master.sv
// ----------------------------------------------------------------------------
// tb_apb_master
//   Directed and randomized transfers against apb_master (TIMEOUT_CYCLES=4).
//   The bench plays the APB completer: a sparse memory answers reads, and the
//   number of wait cycles and the error flag are chosen per transfer. Expected
//   responses come from transfer-level rules (access-cycle count, timeout,
//   read data) rather than from cycle-level state tracking.
// ----------------------------------------------------------------------------
module tb_apb_master;

    localparam int TO = 4;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int n_done = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] last_rd;
    logic        last_err;
    logic        last_to;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Count completion pulses seen mid-cycle.
    always @(negedge pclk) begin
        if (rsp_valid === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0000_0000;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One complete transfer; called at #1 after an edge with the DUT in IDLE.
    // waits = access cycles the completer holds pready low before answering.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic err, input logic hold);
        int          n_acc;
        logic        exp_to;
        logic [31:0] exp_rd;
        exp_to = (waits >= TO);
        n_acc  = exp_to ? TO : waits + 1;
        exp_rd = (!wr && !err && !exp_to) ? mem_rd(addr) : 32'h0000_0000;

        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);
        prdata    = $urandom;
        step();
        // SETUP cycle
        chk("setup_psel",    {31'd0, psel},    32'd1);
        chk("setup_penable", {31'd0, penable}, 32'd0);
        chk("setup_paddr",   paddr,            addr);
        chk("setup_pwrite",  {31'd0, pwrite},  {31'd0, wr});
        if (wr) chk("setup_pwdata", pwdata, wd);
        chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("hold_rsp_rdata",  rsp_rdata,  last_rd);
        chk("hold_rsp_slverr", {31'd0, rsp_slverr},  {31'd0, last_err});
        chk("hold_rsp_timeout", {31'd0, rsp_timeout}, {31'd0, last_to});
        cmd_valid = hold ? 1'b1 : 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);
        prdata    = $urandom;
        step();
        // ACCESS cycles
        for (int i = 0; i < n_acc; i++) begin
            chk("acc_psel",    {31'd0, psel},    32'd1);
            chk("acc_penable", {31'd0, penable}, 32'd1);
            chk("acc_paddr",   paddr,            addr);
            chk("acc_pwrite",  {31'd0, pwrite},  {31'd0, wr});
            if (wr) chk("acc_pwdata", pwdata, wd);
            chk("acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("acc_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            if (i == waits) begin
                pready  = 1'b1;
                pslverr = err;
                prdata  = (wr || err) ? $urandom : mem_rd(addr);
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            step();
        end
        // Completion edge has just passed
        chk("done_rsp_valid",   {31'd0, rsp_valid},   32'd1);
        chk("done_rsp_rdata",   rsp_rdata,            exp_rd);
        chk("done_rsp_slverr",  {31'd0, rsp_slverr},  {31'd0, (err && !exp_to) || exp_to});
        chk("done_rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
        chk("done_psel",    {31'd0, psel},    32'd0);
        chk("done_penable", {31'd0, penable}, 32'd0);
        chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        if (wr && !err && !exp_to) mem[addr] = wd;
        last_rd  = exp_rd;
        last_err = err || exp_to;
        last_to  = exp_to;
        n_done++;
        pready  = 1'b0;
        pslverr = 1'b0;
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        int p0;
        presetn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_1234;
        cmd_wdata = 32'h5555_AAAA;
        pready    = 1'b1;
        pslverr   = 1'b1;
        prdata    = 32'hFFFF_FFFF;
        last_rd   = 32'h0000_0000;
        last_err  = 1'b0;
        last_to   = 1'b0;

        // Reset state, with a command and completer activity present.
        step();
        step();
        chk("rst_psel",        {31'd0, psel},        32'd0);
        chk("rst_penable",     {31'd0, penable},     32'd0);
        chk("rst_pwrite",      {31'd0, pwrite},      32'd0);
        chk("rst_paddr",       paddr,                32'h0000_0000);
        chk("rst_pwdata",      pwdata,               32'h0000_0000);
        chk("rst_rsp_valid",   {31'd0, rsp_valid},   32'd0);
        chk("rst_rsp_rdata",   rsp_rdata,            32'h0000_0000);
        chk("rst_rsp_slverr",  {31'd0, rsp_slverr},  32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_cmd_ready",   {31'd0, cmd_ready},   32'd1);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        presetn   = 1'b1;
        step();
        chk("post_rst_psel", {31'd0, psel}, 32'd0);

        // Zero-wait write, then waited read of the same address.
        xfer(1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        step();
        xfer(1'b0, 32'h0000_0005, 32'h0000_0000, 3, 1'b0, 1'b0);
        chk("read_back_deadbeef", rsp_rdata, 32'hDEAD_BEEF);
        step();
        // Completer error on a read.
        xfer(1'b0, 32'h0000_0040, 32'h0000_0000, 0, 1'b1, 1'b0);
        step();
        // Timeout abort, then pready on the last allowed cycle.
        xfer(1'b1, 32'h0000_0010, 32'h1111_2222, TO, 1'b0, 1'b0);
        step();
        xfer(1'b0, 32'h0000_0005, 32'h0000_0000, TO - 1, 1'b0, 1'b0);

        // Three back-to-back writes with cmd_valid held high.
        step();
        p0 = pulses;
        xfer(1'b1, 32'h0000_0020, 32'hA0A0_0001, 0, 1'b0, 1'b1);
        xfer(1'b1, 32'h0000_0024, 32'hA0A0_0002, 0, 1'b0, 1'b1);
        xfer(1'b1, 32'h0000_0028, 32'hA0A0_0003, 1, 1'b0, 1'b0);
        step();
        chk("b2b_pulses", 32'(pulses - p0), 32'd3);

        // Reset during ACCESS: bus drops, no completion.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0030;
        cmd_wdata = 32'h7777_7777;
        step();
        cmd_valid = 1'b0;
        step();
        pready = 1'b0;
        step();
        chk("pre_rst_penable", {31'd0, penable}, 32'd1);
        p0 = pulses;
        presetn = 1'b0;
        pready  = 1'b1;
        step();
        chk("midrst_psel",      {31'd0, psel},      32'd0);
        chk("midrst_penable",   {31'd0, penable},   32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        presetn = 1'b1;
        pready  = 1'b0;
        step();
        chk("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        last_rd  = 32'h0000_0000;
        last_err = 1'b0;
        last_to  = 1'b0;
        xfer(1'b0, 32'h0000_0024, 32'h0000_0000, 0, 1'b0, 1'b0);

        // Randomized transfers against the memory model.
        for (int n = 0; n < 40; n++) begin
            logic        r_wr;
            logic [31:0] r_addr;
            logic        r_err;
            logic        r_hold;
            r_wr   = 1'($urandom);
            r_addr = 32'($urandom_range(0, 7)) << 2;
            r_err  = ($urandom_range(0, 7) == 0);
            r_hold = (n < 39) ? 1'($urandom) : 1'b0;
            xfer(r_wr, r_addr, $urandom, int'($urandom_range(0, TO + 1)), r_err, r_hold);
            if (!r_hold) step();
        end
        step();
        chk("pulse_total", 32'(pulses), 32'(n_done));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: ACCESS cycles with pready low before the master aborts; legal range 1..255.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 pclk  input  1  sole clock; all state changes on rising edge.
REQ-004 presetn  input  1  synchronous active-low reset, sampled on pclk rising edge.
REQ-005 cmd_valid  input  1  local requester presents a transfer.
REQ-006 cmd_ready  output  1  master can accept a command this cycle.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  32  transfer address.
REQ-009 cmd_wdata  input  32  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle pulse: transfer complete, rsp_* valid.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and error completions.
REQ-012 rsp_slverr  output  1  completion carried error (pslverr or timeout).
REQ-013 rsp_timeout  output  1  completion was a timeout abort.
REQ-014 paddr, pwdata  output  32 each  APB address and write data, registered.
REQ-015 psel, penable, pwrite  output  1 each  APB control, registered.
REQ-016 pready, pslverr  input  1 each  completer handshake and error.
REQ-017 prdata  input  32  completer read data.

Function
REQ-018 FSM SHALL have states IDLE, SETUP, ACCESS; only IDLE asserts cmd_ready (combinational from state).
REQ-019 IDLE: on cmd_valid=1 at an edge, latch cmd_addr/cmd_wdata/cmd_write into paddr/pwdata/pwrite, drive psel=1 penable=0, go to SETUP; else stay, psel=penable=0.
REQ-020 SETUP lasts exactly one cycle; next edge sets penable=1, goes to ACCESS, clears wait counter.
REQ-021 paddr, pwdata, pwrite SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-022 ACCESS, pready=1 at edge: psel=penable=0, rsp_valid=1 for one cycle, rsp_slverr=pslverr, rsp_timeout=0, rsp_rdata=prdata if read and pslverr=0 else 0; go to IDLE.
REQ-023 ACCESS, pready=0 at edge: wait counter increments; when counter reaches TIMEOUT_CYCLES, abort as REQ-022 but rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-024 pready=1 on the same edge the counter would reach TIMEOUT_CYCLES SHALL complete normally (pready wins).
REQ-025 Minimum latency: command accepted at edge N -> rsp_valid high after edge N+2 with zero-wait completer; next command accepted no earlier than edge N+3 (one IDLE cycle between transfers).
REQ-026 rsp_valid has no backpressure; rsp_* hold last values while rsp_valid=0.
REQ-027 pslverr and prdata SHALL be ignored outside ACCESS-with-pready.
REQ-028 cmd_valid during SETUP/ACCESS SHALL be ignored (not queued).

Reset
REQ-029 presetn=0 at an edge: state IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_slverr=rsp_timeout=0, rsp_rdata=0, wait counter=0.
REQ-030 Reset mid-transfer SHALL drop psel/penable at that edge with no rsp_valid pulse for the aborted transfer.

Verification
REQ-031 Write 0x0000_0005 <- 0xDEAD_BEEF, zero-wait completer -> one SETUP cycle, one ACCESS cycle, rsp_valid pulse, rsp_slverr=0, rsp_rdata=0.
REQ-032 Read 0x05 after REQ-031, completer waits 3 cycles -> penable high 4 cycles, paddr stable, rsp_rdata=0xDEAD_BEEF.
REQ-033 Read 0x40, completer pslverr=1 with pready -> rsp_slverr=1, rsp_timeout=0, rsp_rdata=0.
REQ-034 TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_slverr=1, rsp_timeout=1; pready=1 on 4th cycle instead -> normal completion.
REQ-035 cmd_valid held high for 3 back-to-back writes -> cmd_ready only in IDLE, exactly 3 rsp_valid pulses, one idle cycle between transfers.
REQ-036 presetn=0 during ACCESS -> psel=penable=0 next edge, no rsp_valid, new command accepted after reset release.
